axi4l_regs: RTL and testbench
=============================

AXI4L_REGS -- requirements
Module: axi4l_regs

Interface
REQ-001 Parameter BASE_OFFSET, default 32'h80000000: base address of the register window.
REQ-002 Parameter BASE_OFFSET_MASK, default 32'h0000FFFF: address bits set here are offset bits; all other bits must equal BASE_OFFSET.
REQ-003 Parameter REG_ADDR_WIDTH, default 2: word-index width of the register space.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 rstn  in  1  reset; asynchronous, active-low.
REQ-006 s_axi_awaddr in 32, s_axi_awvalid in 1, s_axi_awready out 1: AXI4-Lite write address channel.
REQ-007 s_axi_wdata in 32, s_axi_wstrb in 4, s_axi_wvalid in 1, s_axi_wready out 1: write data channel.
REQ-008 s_axi_bresp out 2, s_axi_bvalid out 1, s_axi_bready in 1: write response channel.
REQ-009 s_axi_araddr in 32, s_axi_arvalid in 1, s_axi_arready out 1: read address channel.
REQ-010 s_axi_rdata out 32, s_axi_rresp out 2, s_axi_rvalid out 1, s_axi_rready in 1: read data channel.
REQ-011 reg_addr out REG_ADDR_WIDTH, reg_wdata out 32, reg_wren out 1 (1 = write, 0 = read), reg_be out 4: register request fields.
REQ-012 reg_rdata in 32, reg_req out 1, reg_ack in 1, reg_err in 1: register request/completion.

Function
REQ-013 The FSM SHALL use states IDLE, RD_REQ, RD_WAIT, RD_RESP, WR_REQ, WR_WAIT, WR_RESP.
REQ-014 In IDLE, arvalid SHALL have priority; arready pulses 1 cycle and the address is latched.
REQ-015 In IDLE with no arvalid, and both awvalid and wvalid high, awready and wready SHALL pulse together for 1 cycle; address, data and strobe are latched; neither channel is accepted alone.
REQ-016 Decode: hit when (addr & ~BASE_OFFSET_MASK) == BASE_OFFSET and offset bits above [REG_ADDR_WIDTH+1] are zero; reg_addr = addr[REG_ADDR_WIDTH+1:2]; addr[1:0] ignored.
REQ-017 On a miss, no reg_req SHALL be issued; the response state is entered next cycle with resp DECERR (2'b11), rdata 0.
REQ-018 On a hit, reg_req SHALL pulse high exactly one cycle (RD_REQ/WR_REQ); reg_addr, reg_wdata, reg_be, reg_wren hold stable from that cycle until completion.
REQ-019 In RD_WAIT/WR_WAIT, the first cycle with reg_ack or reg_err completes; reg_err (alone or with reg_ack) gives SLVERR (2'b10), reg_ack alone gives OKAY (2'b00); reg_rdata is captured on OKAY read completion, rdata 0 otherwise.
REQ-020 reg_ack/reg_err outside a WAIT state SHALL be ignored.
REQ-021 rvalid/bvalid SHALL assert the cycle after completion and hold with stable data/resp until rready/bready; then return to IDLE.
REQ-022 Hit-read latency: AR handshake cycle N, reg_req N+1, earliest reg_ack N+2, rvalid N+3.
REQ-023 A new transaction SHALL NOT be accepted until the current response handshakes (one outstanding).

Reset
REQ-024 While rstn is low: state IDLE; all ready/valid outputs, reg_req, reg_wren 0; bresp, rresp, rdata, reg_addr, reg_wdata, reg_be 0.
REQ-025 Reset mid-transaction SHALL abandon it with no response issued.

Configuration
REQ-026 Macro AXI4L_REGS_TIMEOUT_EN defined: if no reg_ack/reg_err within REG_TIMEOUT_CYCLES (16) cycles after reg_req, complete with SLVERR, rdata 0.
REQ-027 Macro undefined: WAIT states wait indefinitely; no counter logic is present.

Structure
REQ-028 Package axi4l_pkg SHALL hold the response constants OKAY/EXOKAY/SLVERR/DECERR, the FSM state enum, and REG_TIMEOUT_CYCLES.
REQ-029 Address decode SHALL be a sub-module axi4l_addr_decode (combinational: addr in -> hit, reg index out).

Verification (bench pairs the DUT with reg_block: 4 regs, all readable, reg 1 read-only, error on write to it, 1-cycle ack, reset contents 0)
REQ-030 After reset, read 0x80000000, 0x80000004, 0x80000008, 0x8000000C -> rresp OKAY, rdata 0x00000000, one reg_req each.
REQ-031 Read 0x80000010 and 0x90000000 -> rresp DECERR, rdata 0, reg_req never asserted.
REQ-032 Write 0xDEADBEEF, wstrb 4'hF to 0x80000008 -> bresp OKAY; readback -> 0xDEADBEEF; write 0x00000011, wstrb 4'h1 to the same address -> readback 0xDEADBE11.
REQ-033 Write 0x12345678 to 0x80000004 -> reg_err, bresp SLVERR; readback 0x00000000.
REQ-034 arvalid, awvalid, wvalid raised in the same cycle -> read completes first, write accepted only after rready handshake; rready held low 5 cycles -> rvalid/rdata stable.
REQ-035 With AXI4L_REGS_TIMEOUT_EN and a responder that never acks -> SLVERR 16 cycles after reg_req.

Source files
------------

// File: rtl/axi4l_pkg.sv
// ============================================================================
// axi4l_pkg : shared response codes, FSM state type and timeout length
// Revision  : 1.0
// ============================================================================
`default_nettype none

package axi4l_pkg;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] EXOKAY = 2'b01;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

   localparam int unsigned REG_TIMEOUT_CYCLES = 16;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_WAIT = 3'd2,
      RD_RESP = 3'd3,
      WR_REQ  = 3'd4,
      WR_WAIT = 3'd5,
      WR_RESP = 3'd6
   } state_e;

endpackage

`default_nettype wire

// File: rtl/axi4l_addr_decode.sv
// ============================================================================
// axi4l_addr_decode : combinational window match and word index extraction
// Revision          : 1.0
// ============================================================================
`default_nettype none

module axi4l_addr_decode #(
   parameter logic [31:0] BASE_OFFSET      = 32'h8000_0000,
   parameter logic [31:0] BASE_OFFSET_MASK = 32'h0000_FFFF,
   parameter int          REG_ADDR_WIDTH   = 2
) (
   input  logic [31:0]               addr_i,
   output logic                      hit_o,
   output logic [REG_ADDR_WIDTH-1:0] idx_o
);

   // Offset bits above the register index must be zero for a hit.
   localparam logic [31:0] IDX_SPAN_MASK    = (32'h1 << (REG_ADDR_WIDTH + 2)) - 32'h1;
   localparam logic [31:0] HIGH_OFFSET_MASK = BASE_OFFSET_MASK & ~IDX_SPAN_MASK;

   assign hit_o = ((addr_i & ~BASE_OFFSET_MASK) == BASE_OFFSET) &&
                  ((addr_i & HIGH_OFFSET_MASK) == 32'h0);
   assign idx_o = addr_i[REG_ADDR_WIDTH+1:2];

endmodule

`default_nettype wire

// File: rtl/axi4l_regs.sv
// ============================================================================
// axi4l_regs : AXI4-Lite slave bridging to a simple req/ack register port.
//              Optional AXI4L_REGS_TIMEOUT_EN adds a SLVERR completion timeout.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module axi4l_regs
   import axi4l_pkg::*;
#(
   parameter logic [31:0] BASE_OFFSET      = 32'h8000_0000,
   parameter logic [31:0] BASE_OFFSET_MASK = 32'h0000_FFFF,
   parameter int          REG_ADDR_WIDTH   = 2
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic [31:0]               s_axi_awaddr,
   input  logic                      s_axi_awvalid,
   output logic                      s_axi_awready,
   input  logic [31:0]               s_axi_wdata,
   input  logic [3:0]                s_axi_wstrb,
   input  logic                      s_axi_wvalid,
   output logic                      s_axi_wready,
   output logic [1:0]                s_axi_bresp,
   output logic                      s_axi_bvalid,
   input  logic                      s_axi_bready,
   input  logic [31:0]               s_axi_araddr,
   input  logic                      s_axi_arvalid,
   output logic                      s_axi_arready,
   output logic [31:0]               s_axi_rdata,
   output logic [1:0]                s_axi_rresp,
   output logic                      s_axi_rvalid,
   input  logic                      s_axi_rready,
   output logic [REG_ADDR_WIDTH-1:0] reg_addr,
   output logic [31:0]               reg_wdata,
   output logic                      reg_wren,
   output logic [3:0]                reg_be,
   input  logic [31:0]               reg_rdata,
   output logic                      reg_req,
   input  logic                      reg_ack,
   input  logic                      reg_err
);

   state_e                    state_q, state_d;
   logic [REG_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]               wdata_q, wdata_d;
   logic [3:0]                be_q, be_d;
   logic                      wren_q, wren_d;
   logic [1:0]                resp_q, resp_d;
   logic [31:0]               rdata_q, rdata_d;

   logic [31:0]               dec_addr;
   logic                      dec_hit;
   logic [REG_ADDR_WIDTH-1:0] dec_idx;
   logic                      tmo_expired;

   // Read has priority, so the decoder follows the read address whenever it is offered.
   assign dec_addr = s_axi_arvalid ? s_axi_araddr : s_axi_awaddr;

   axi4l_addr_decode #(
      .BASE_OFFSET      (BASE_OFFSET),
      .BASE_OFFSET_MASK (BASE_OFFSET_MASK),
      .REG_ADDR_WIDTH   (REG_ADDR_WIDTH)
   ) u_addr_decode (
      .addr_i (dec_addr),
      .hit_o  (dec_hit),
      .idx_o  (dec_idx)
   );

`ifdef AXI4L_REGS_TIMEOUT_EN
   localparam int TMO_W = $clog2(REG_TIMEOUT_CYCLES + 1);

   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             in_wait;

   assign in_wait = (state_q == RD_WAIT) || (state_q == WR_WAIT);

   always_comb begin
      tmo_cnt_d = '0;
      if (in_wait) begin
         tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tmo_cnt_q <= '0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
      end
   end

   // Count is zero on the first wait cycle, so this fires on the last allowed one.
   assign tmo_expired = in_wait && (tmo_cnt_q == TMO_W'(REG_TIMEOUT_CYCLES - 1));
`else
   assign tmo_expired = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      be_d          = be_q;
      wren_d        = wren_q;
      resp_d        = resp_q;
      rdata_d       = rdata_q;
      s_axi_arready = 1'b0;
      s_axi_awready = 1'b0;
      s_axi_wready  = 1'b0;

      case (state_q)
         IDLE: begin
            if (rstn && s_axi_arvalid) begin
               s_axi_arready = 1'b1;
               addr_d        = dec_idx;
               wren_d        = 1'b0;
               if (dec_hit) begin
                  state_d = RD_REQ;
               end else begin
                  resp_d  = DECERR;
                  rdata_d = '0;
                  state_d = RD_RESP;
               end
            end else if (rstn && s_axi_awvalid && s_axi_wvalid) begin
               s_axi_awready = 1'b1;
               s_axi_wready  = 1'b1;
               addr_d        = dec_idx;
               wdata_d       = s_axi_wdata;
               be_d          = s_axi_wstrb;
               wren_d        = 1'b1;
               if (dec_hit) begin
                  state_d = WR_REQ;
               end else begin
                  resp_d  = DECERR;
                  state_d = WR_RESP;
               end
            end
         end
         RD_REQ:  state_d = RD_WAIT;
         RD_WAIT: begin
            if (reg_err || tmo_expired) begin
               resp_d  = SLVERR;
               rdata_d = '0;
               state_d = RD_RESP;
            end else if (reg_ack) begin
               resp_d  = OKAY;
               rdata_d = reg_rdata;
               state_d = RD_RESP;
            end
         end
         RD_RESP: begin
            if (s_axi_rready) begin
               state_d = IDLE;
            end
         end
         WR_REQ:  state_d = WR_WAIT;
         WR_WAIT: begin
            if (reg_err || tmo_expired) begin
               resp_d  = SLVERR;
               state_d = WR_RESP;
            end else if (reg_ack) begin
               resp_d  = OKAY;
               state_d = WR_RESP;
            end
         end
         WR_RESP: begin
            if (s_axi_bready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         wren_q  <= 1'b0;
         resp_q  <= OKAY;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         wren_q  <= wren_d;
         resp_q  <= resp_d;
         rdata_q <= rdata_d;
      end
   end

   assign reg_req      = (state_q == RD_REQ) || (state_q == WR_REQ);
   assign reg_addr     = addr_q;
   assign reg_wdata    = wdata_q;
   assign reg_be       = be_q;
   assign reg_wren     = wren_q;
   assign s_axi_rvalid = (state_q == RD_RESP);
   assign s_axi_bvalid = (state_q == WR_RESP);
   assign s_axi_rresp  = resp_q;
   assign s_axi_bresp  = resp_q;
   assign s_axi_rdata  = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_axi4l_regs.sv
// ============================================================================
// tb_axi4l_regs : directed + randomized bench for axi4l_regs with a 4-register
//                 responder (reg 1 read-only) and a behavioural register model
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_axi4l_regs;
   import axi4l_pkg::*;

   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] awaddr, wdata, araddr, rdata, reg_wdata, reg_rdata;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [3:0]  wstrb, reg_be;
   logic [1:0]  bresp, rresp, reg_addr;
   logic        reg_wren, reg_req, rb_ack, rb_err, stray_ack, rb_mute;

   int checks   = 0;
   int failures = 0;
   int req_cnt  = 0;

   logic [31:0] rb_regs [4];
   logic [31:0] exp_regs [4];

   always #5 clk = ~clk;

   axi4l_regs dut (
      .clk(clk), .rstn(rstn),
      .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
      .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wren(reg_wren), .reg_be(reg_be),
      .reg_rdata(reg_rdata), .reg_req(reg_req), .reg_ack(rb_ack | stray_ack), .reg_err(rb_err)
   );

   // Register block: one-cycle ack, writes to reg 1 answered with an error.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rb_ack    <= 1'b0;
         rb_err    <= 1'b0;
         reg_rdata <= '0;
         for (int i = 0; i < 4; i++) rb_regs[i] <= '0;
      end else begin
         rb_ack <= 1'b0;
         rb_err <= 1'b0;
         if (reg_req && !rb_mute) begin
            if (reg_wren && reg_addr == 2'd1) begin
               rb_err <= 1'b1;
            end else begin
               rb_ack    <= 1'b1;
               reg_rdata <= rb_regs[reg_addr];
               if (reg_wren)
                  for (int b = 0; b < 4; b++)
                     if (reg_be[b]) rb_regs[reg_addr][8*b +: 8] <= reg_wdata[8*b +: 8];
            end
         end
      end
   end

   always @(posedge clk) if (reg_req) req_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit model_hit(input logic [31:0] a);
      return (a[31:16] == 16'h8000) && (a[15:4] == 12'h000);
   endfunction

   task automatic axi_read(input logic [31:0] a, input int hold, output logic [31:0] d,
                           output logic [1:0] r, output int lat);
      int t;
      @(negedge clk); araddr = a; arvalid = 1'b1; t = 0;
      #1;
      while (!arready && t < 50) begin @(negedge clk); #1; t++; end
      chk("ar_handshake_bound", t < 50, 1);
      @(negedge clk); arvalid = 1'b0; lat = 1;
      #1;
      while (!rvalid && lat < 60) begin @(negedge clk); #1; lat++; end
      chk("rvalid_bound", rvalid, 1);
      d = rdata; r = rresp;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk); #1;
         chk("r_hold_stable", {rvalid, rresp, rdata}, {1'b1, r, d});
      end
      rready = 1'b1;
      @(negedge clk); rready = 1'b0;
   endtask

   task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int hold, output logic [1:0] r);
      int t;
      @(negedge clk); awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; t = 0;
      #1;
      while (!(awready && wready) && t < 50) begin @(negedge clk); #1; t++; end
      chk("aw_handshake_bound", t < 50, 1);
      @(negedge clk); awvalid = 1'b0; wvalid = 1'b0; t = 0;
      #1;
      while (!bvalid && t < 60) begin @(negedge clk); #1; t++; end
      chk("bvalid_bound", bvalid, 1);
      r = bresp;
      repeat (hold) begin @(negedge clk); #1; chk("b_hold_stable", {bvalid, bresp}, {1'b1, r}); end
      bready = 1'b1;
      @(negedge clk); bready = 1'b0;
   endtask

   task automatic check_read(input logic [31:0] a, input int hold, input string tag);
      logic [31:0] d; logic [1:0] r; int lat; int n0;
      n0 = req_cnt;
      axi_read(a, hold, d, r, lat);
      if (model_hit(a)) begin
         chk({tag, "_data"}, d, exp_regs[a[3:2]]);
         chk({tag, "_resp"}, r, OKAY);
         chk({tag, "_nreq"}, req_cnt - n0, 1);
         chk({tag, "_lat"}, lat, 3);
      end else begin
         chk({tag, "_data"}, d, 0);
         chk({tag, "_resp"}, r, DECERR);
         chk({tag, "_nreq"}, req_cnt - n0, 0);
         chk({tag, "_lat"}, lat, 1);
      end
   endtask

   task automatic check_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                              input int hold, input string tag);
      logic [1:0] r; int n0; logic [1:0] er;
      n0 = req_cnt;
      axi_write(a, d, s, hold, r);
      if (!model_hit(a)) er = DECERR;
      else if (a[3:2] == 2'd1) er = SLVERR;
      else begin
         er = OKAY;
         for (int b = 0; b < 4; b++) if (s[b]) exp_regs[a[3:2]][8*b +: 8] = d[8*b +: 8];
      end
      chk({tag, "_bresp"}, r, er);
      chk({tag, "_nreq"}, req_cnt - n0, model_hit(a) ? 1 : 0);
   endtask

   initial begin
      logic [31:0] a, d0; int t; bit seen;
      rstn = 1'b0; rb_mute = 1'b0; stray_ack = 1'b0;
      awaddr = '0; wdata = '0; wstrb = '0; awvalid = 0; wvalid = 0; bready = 0;
      araddr = '0; arvalid = 1'b1; rready = 0;
      for (int i = 0; i < 4; i++) exp_regs[i] = '0;

      // Reset state, with a read request already offered
      repeat (3) @(negedge clk);
      #1;
      chk("rst_handshake", {arready, awready, wready, bvalid, rvalid, reg_req, reg_wren}, 0);
      chk("rst_resp", {bresp, rresp, reg_addr, reg_be}, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_wdata", reg_wdata, 0);
      arvalid = 1'b0;
      @(negedge clk); rstn = 1'b1;

      // Reset contents of every register
      for (int i = 0; i < 4; i++) check_read(32'h8000_0000 + 32'(i * 4), 0, "rd_reset");

      // Decode misses
      check_read(32'h8000_0010, 0, "rd_miss_off");
      check_read(32'h9000_0000, 0, "rd_miss_base");

      // Full and partial writes with readback
      check_write(32'h8000_0008, 32'hDEAD_BEEF, 4'hF, 0, "wr_full");
      check_read(32'h8000_0008, 0, "rd_full");
      chk("rd_full_const", exp_regs[2], 32'hDEAD_BEEF);
      check_write(32'h8000_0008, 32'h0000_0011, 4'h1, 1, "wr_byte");
      check_read(32'h8000_0008, 0, "rd_byte");
      chk("rd_byte_const", exp_regs[2], 32'hDEAD_BE11);

      // Read-only register
      check_write(32'h8000_0004, 32'h1234_5678, 4'hF, 0, "wr_ro");
      check_read(32'h8000_0004, 0, "rd_ro");

      // Ack with no request outstanding must not complete anything
      @(negedge clk); stray_ack = 1'b1;
      @(negedge clk); stray_ack = 1'b0; #1;
      chk("stray_ack", {rvalid, bvalid, reg_req}, 0);

      // Simultaneous read and write: read wins, write waits for rready
      @(negedge clk);
      araddr = 32'h8000_0008; awaddr = 32'h8000_000C; wdata = 32'hA5A5_0F0F; wstrb = 4'hF;
      arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
      #1;
      chk("conc_ar_first", {arready, awready, wready}, 3'b100);
      @(negedge clk); arvalid = 1'b0; seen = 0; t = 0;
      #1;
      while (!rvalid && t < 20) begin
         if (awready || wready) seen = 1;
         @(negedge clk); #1; t++;
      end
      chk("conc_rvalid", rvalid, 1);
      d0 = rdata;
      chk("conc_rdata", d0, exp_regs[2]);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         if (awready || wready) seen = 1;
         chk("conc_hold", {rvalid, rresp, rdata}, {1'b1, OKAY, d0});
      end
      chk("conc_no_early_aw", seen, 0);
      rready = 1'b1;
      @(negedge clk); rready = 1'b0; #1;
      chk("conc_aw_after_r", {awready, wready}, 2'b11);
      @(negedge clk); awvalid = 1'b0; wvalid = 1'b0; t = 0;
      #1;
      while (!bvalid && t < 20) begin @(negedge clk); #1; t++; end
      chk("conc_bresp", {bvalid, bresp}, {1'b1, OKAY});
      exp_regs[3] = 32'hA5A5_0F0F;
      bready = 1'b1;
      @(negedge clk); bready = 1'b0;
      check_read(32'h8000_000C, 0, "conc_rdback");

      // Randomized traffic
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 3))
            0, 1: a = 32'h8000_0000 | 32'($urandom_range(0, 3) << 2) | 32'($urandom_range(0, 3));
            2:    a = 32'h8000_0000 | 32'($urandom_range(1, 4095) << 4) | 32'($urandom_range(0, 15));
            default: a = {16'h8000 ^ 16'($urandom_range(1, 65535)), 16'($urandom)};
         endcase
         if ($urandom_range(0, 1) == 1)
            check_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), "rnd_wr");
         else
            check_read(a, $urandom_range(0, 3), "rnd_rd");
      end
      for (int i = 0; i < 4; i++) check_read(32'h8000_0000 + 32'(i * 4), 0, "rnd_final");

`ifdef AXI4L_REGS_TIMEOUT_EN
      begin
         logic [31:0] td; logic [1:0] tr; int tl;
         rb_mute = 1'b1;
         axi_read(32'h8000_0000, 0, td, tr, tl);
         chk("tmo_resp", tr, SLVERR);
         chk("tmo_data", td, 0);
         chk("tmo_lat", tl, 18);
         rb_mute = 1'b0;
      end
`endif

      // Reset in the middle of a read abandons it silently
      @(negedge clk); araddr = 32'h8000_0008; arvalid = 1'b1;
      @(negedge clk); arvalid = 1'b0; #1;
      chk("mid_req", reg_req, 1);
      rstn = 1'b0;
      for (int i = 0; i < 4; i++) exp_regs[i] = '0;
      repeat (2) @(negedge clk);
      rstn = 1'b1; seen = 0;
      repeat (5) begin @(negedge clk); #1; if (rvalid || bvalid || reg_req) seen = 1; end
      chk("mid_no_resp", seen, 0);
      check_read(32'h8000_0008, 0, "mid_rdback");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
